// File: rtl/decode_pkg.sv
// Shared decode definitions for the decode/immediate stage.
//   imm_src_t     : immediate format (I/S/B) carried with each instruction
//   stage_state_t : occupancy of the decode/execute register plus skid slot
//   entry_t       : one held instruction (instr, pc, imm, format, illegal)
//   op_supported  : true for opcodes this stage knows how to decode
//   op_immsrc     : immediate format for an opcode (I for unknown opcodes)
package decode_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;

  typedef enum logic [1:0] {
    ImmI = 2'b00,
    ImmS = 2'b01,
    ImmB = 2'b10
  } imm_src_t;

  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StFull  = 2'b01,
    StSkid  = 2'b10
  } stage_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    imm_src_t        immsrc;
    logic            illegal;
  } entry_t;

  function automatic logic op_supported(input logic [6:0] op);
    return (op == OpLoad) || (op == OpImm) || (op == OpJalr) || (op == OpReg) ||
           (op == OpStore) || (op == OpBranch);
  endfunction

  function automatic imm_src_t op_immsrc(input logic [6:0] op);
    imm_src_t src;
    src = ImmI;
    if (op == OpStore) begin
      src = ImmS;
    end else if (op == OpBranch) begin
      src = ImmB;
    end
    return src;
  endfunction

endpackage

// File: rtl/sign_extend.sv
// Immediate extraction and sign extension for I, S and B formats.
// Ports:
//   instr_i  : instruction word
//   immsrc_i : immediate format selecting the bit scatter
//   imm_o    : sign-extended immediate (B format includes the implicit 0 LSB)
// Only DATA_WIDTH = 32 is supported.
module sign_extend
  import decode_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] instr_i,
  input  imm_src_t              immsrc_i,
  output logic [DATA_WIDTH-1:0] imm_o
);

  // Opcode bits carry no immediate payload.
  logic unused_opcode;
  assign unused_opcode = ^instr_i[6:0];

  always_comb begin
    imm_o = '0;
    unique case (immsrc_i)
      ImmI:    imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      ImmS:    imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      ImmB:    imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                        instr_i[11:8], 1'b0};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/decode_imm_stage.sv
// Decode/immediate stage: decodes the immediate format of the incoming instruction, builds
// its sign-extended immediate and registers it into the decode/execute register, with a
// one-entry skid buffer so an instruction accepted during a downstream stall is not lost.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : upstream handshake (in_ready is purely registered)
//   in_instr, in_pc       : incoming instruction and its PC
//   stall                 : downstream hold request
//   flush                 : squash everything held, including a same-cycle accept
//   out_valid             : decode/execute register holds an instruction
//   out_instr/pc/imm      : registered instruction, PC and immediate
//   out_immsrc            : registered immediate format (00 I, 01 S, 10 B)
//   out_illegal           : registered unsupported-opcode flag
// Configuration macro DECODE_ILLEGAL_TRAP_EN: when defined, unsupported opcodes are flagged
// with out_illegal=1 and a zero immediate; otherwise they pass with I-format extension.
module decode_imm_stage
  import decode_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_instr,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [DATA_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_imm,
  output logic [1:0]            out_immsrc,
  output logic                  out_illegal
);

  stage_state_t state_q, state_d;
  entry_t       out_q, out_d;
  entry_t       skid_q, skid_d;
  logic         ready_q, ready_d;

  imm_src_t              dec_immsrc;
  logic                  dec_illegal;
  logic [DATA_WIDTH-1:0] ext_imm;
  entry_t                in_entry;
  logic                  accept;

  always_comb begin
    dec_immsrc = op_immsrc(in_instr[6:0]);
`ifdef DECODE_ILLEGAL_TRAP_EN
    dec_illegal = !op_supported(in_instr[6:0]);
`else
    dec_illegal = 1'b0;
`endif
  end

  sign_extend #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_sign_extend (
    .instr_i (in_instr),
    .immsrc_i(dec_immsrc),
    .imm_o   (ext_imm)
  );

  always_comb begin
    in_entry.instr   = in_instr;
    in_entry.pc      = in_pc;
    in_entry.imm     = dec_illegal ? '0 : ext_imm;
    in_entry.immsrc  = dec_illegal ? ImmI : dec_immsrc;
    in_entry.illegal = dec_illegal;
  end

  assign accept = in_valid & ready_q;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;

    unique case (state_q)
      StEmpty: begin
        // Stall is irrelevant here: nothing is presented downstream.
        if (accept) begin
          out_d   = in_entry;
          state_d = StFull;
        end
      end
      StFull: begin
        if (!stall) begin
          if (accept) begin
            out_d = in_entry;
          end else begin
            state_d = StEmpty;
          end
        end else if (accept) begin
          skid_d  = in_entry;
          state_d = StSkid;
        end
      end
      StSkid: begin
        if (!stall) begin
          out_d   = skid_q;
          state_d = StFull;
        end
      end
      default: state_d = StEmpty;
    endcase

    // Flush wins: drop both held entries and anything accepted this cycle.
    if (flush) begin
      state_d = StEmpty;
      out_d   = out_q;
      skid_d  = skid_q;
    end
  end

  // Ready is registered from the next state so it never depends on same-cycle inputs,
  // and stays low until the first edge after reset.
  assign ready_d = (state_d != StSkid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      out_q   <= '0;
      skid_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
    end
  end

  assign in_ready    = ready_q;
  assign out_valid   = (state_q != StEmpty);
  assign out_instr   = out_q.instr;
  assign out_pc      = out_q.pc;
  assign out_imm     = out_q.imm;
  assign out_immsrc  = out_q.immsrc;
  assign out_illegal = out_q.illegal;

endmodule

// File: doc/decode_imm_stage.md
DECODE_IMM_STAGE -- requirements
Module: decode_imm_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the instruction/PC/immediate width; only 32 is supported.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1, upstream instruction valid.
REQ-005 SHALL have port in_ready, output, 1, stage can accept an instruction.
REQ-006 SHALL have port in_instr, input, DATA_WIDTH, fetched instruction.
REQ-007 SHALL have port in_pc, input, DATA_WIDTH, instruction PC.
REQ-008 SHALL have port stall, input, 1, downstream hold request.
REQ-009 SHALL have port flush, input, 1, squash all held instructions.
REQ-010 SHALL have port out_valid, output, 1, decode/execute register holds a valid instruction.
REQ-011 SHALL have ports out_instr, out_pc and out_imm, output, DATA_WIDTH each, the registered instruction, PC and sign-extended immediate.
REQ-012 SHALL have port out_immsrc, output, 2, the registered immediate format: 00 I, 01 S, 10 B.
REQ-013 SHALL have port out_illegal, output, 1, registered unsupported-opcode flag.

Function
REQ-014 SHALL decode in_instr[6:0] combinationally: load 0000011, op-imm 0010011, jalr 1100111 and R-type 0110011 map to 00; store 0100011 maps to 01; branch 1100011 maps to 10; every other opcode is unsupported and maps to 00.
REQ-015 SHALL compute the immediate for the incoming instruction through the sign_extend sub-module; the result is captured with the instruction, giving one-cycle latency from accept to out_*.
REQ-016 SHALL define accept = in_valid & in_ready; in_ready = (state != SKID), driven from registered state only.
REQ-017 SHALL implement FSM EMPTY / FULL / SKID; EMPTY: out_valid=0; FULL: out_valid=1 with the skid entry empty; SKID: out_valid=1 with one entry held in the skid buffer.
REQ-018 SHALL transition from EMPTY to FULL on accept and stay in EMPTY otherwise.
REQ-019 SHALL, in FULL: with !stall & accept, load the new entry and stay in FULL; with !stall & !accept, go to EMPTY; with stall & accept, write the skid buffer and go to SKID; with stall & !accept, hold in FULL.
REQ-020 SHALL, in SKID: with !stall, move the skid entry to out_* and go to FULL; with stall, hold in SKID.
REQ-021 SHALL keep out_* unchanged while stall is high, except via the transitions above.
REQ-022 SHALL give flush priority over all other inputs: next state EMPTY, skid buffer invalidated, any same-cycle accepted instruction discarded.
REQ-023 SHALL ignore stall while the state is EMPTY.

Reset
REQ-024 SHALL, while rst_n is low, force state=EMPTY, in_ready=0, out_valid=0, out_illegal=0, out_immsrc=00 and all data outputs and skid contents to 0.
REQ-025 SHALL assert in_ready=1 on the first clk edge after rst_n deasserts; reset mid-transfer loses both entries without any partial output.

Configuration
REQ-026 SHALL provide macro DECODE_ILLEGAL_TRAP_EN: when defined, an unsupported opcode is accepted with out_illegal=1 and out_imm=0; when undefined, out_illegal is tied 0 and the opcode passes through with I-format extension.

Structure
REQ-027 SHALL place the imm_src_t enum (I/S/B), the opcode localparams and the stage_state_t enum in a shared package decode_pkg.
REQ-028 SHALL instantiate exactly one sub-module: the existing sign_extend, driven by in_instr and the decoded format.

Verification
REQ-029 SHALL test accept of 0xFFF00093 (addi) from EMPTY -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_immsrc=00.
REQ-030 SHALL test 0x00112623 (sw) -> out_imm=0x0000000C, out_immsrc=01; then 0xFE000EE3 (beq) -> out_imm=0xFFFFFFFC, out_immsrc=10.
REQ-031 SHALL test stall held high in FULL while a second instruction is accepted -> state SKID, in_ready=0, out_* unchanged; after stall drops -> the second instruction appears on out_* and in_ready=1.
REQ-032 SHALL test flush asserted in SKID together with in_valid=1 -> next cycle out_valid=0, state EMPTY, and neither instruction is ever presented.
REQ-033 SHALL test opcode 0110111 with the macro defined -> out_illegal=1 and out_imm=0; with it undefined -> out_illegal=0.
REQ-034 SHALL test rst_n pulsed low in FULL in the middle of a cycle -> out_valid=0 immediately, without waiting for clk.
